// File: rtl/scpad_head_arb.sv
// scpad_head_arb
// Per-scratchpad request head. Buffers one request per source (FE, BE),
// arbitrates BE-over-FE with a starvation guard that forces an FE grant
// after STARVE_MAX consecutive BE grants while FE was waiting, and drives
// a registered request toward the body write crossbar.
//
// Ports
//   clk, n_rst                 clock, asynchronous active-low reset
//   fe_valid/write/addr/wdata/mask   FE request in
//   fe_stall                   FE must hold its request
//   be_valid/write/addr/wdata/mask   BE request in
//   be_stall                   BE must hold its request
//   w_stall, r_stall           downstream cannot take a write / read
//   out_valid, out_src         request toward body (src 0=FE, 1=BE)
//   out_write/addr/wdata/mask  request payload
module scpad_head_arb #(
    parameter int ADDR_W     = 20,
    parameter int NUM_COLS   = 32,
    parameter int ELEM_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       fe_valid,
    input  logic                       fe_write,
    input  logic [ADDR_W-1:0]          fe_addr,
    input  logic [NUM_COLS*ELEM_W-1:0] fe_wdata,
    input  logic [NUM_COLS-1:0]        fe_mask,
    output logic                       fe_stall,
    input  logic                       be_valid,
    input  logic                       be_write,
    input  logic [ADDR_W-1:0]          be_addr,
    input  logic [NUM_COLS*ELEM_W-1:0] be_wdata,
    input  logic [NUM_COLS-1:0]        be_mask,
    output logic                       be_stall,
    input  logic                       w_stall,
    input  logic                       r_stall,
    output logic                       out_valid,
    output logic                       out_src,
    output logic                       out_write,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [NUM_COLS*ELEM_W-1:0] out_wdata,
    output logic [NUM_COLS-1:0]        out_mask
);

    localparam int DW = NUM_COLS * ELEM_W;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    // Hold registers
    logic              fe_full_q, be_full_q;
    logic              fe_write_q, be_write_q;
    logic [ADDR_W-1:0] fe_addr_q, be_addr_q;
    logic [DW-1:0]     fe_wdata_q, be_wdata_q;
    logic [NUM_COLS-1:0] fe_mask_q, be_mask_q;

    // Output stage
    logic              out_valid_q, out_src_q, out_write_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DW-1:0]     out_wdata_q;
    logic [NUM_COLS-1:0] out_mask_q;

    logic [CW-1:0]     starve_q, starve_d;

    logic blocked, can_load, grant_fe, grant_be, acc_fe, acc_be;

    // Stall type follows the entry sitting in the output register, so a
    // blocked read also blocks any write queued behind it.
    assign blocked  = out_valid_q & (out_write_q ? w_stall : r_stall);
    assign can_load = ~blocked;

    assign grant_be = can_load & be_full_q & ~((starve_q == SMAX) & fe_full_q);
    assign grant_fe = can_load & fe_full_q & ~grant_be;

    assign fe_stall = fe_full_q & ~grant_fe;
    assign be_stall = be_full_q & ~grant_be;
    assign acc_fe   = fe_valid & ~fe_stall;
    assign acc_be   = be_valid & ~be_stall;

    always_comb begin
        starve_d = starve_q;
        if (grant_fe || !fe_full_q)
            starve_d = '0;
        else if (grant_be && starve_q != SMAX)
            starve_d = starve_q + CW'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fe_full_q  <= 1'b0;
            fe_write_q <= 1'b0;
            fe_addr_q  <= '0;
            fe_wdata_q <= '0;
            fe_mask_q  <= '0;
        end else begin
            if (acc_fe) begin
                fe_full_q  <= 1'b1;
                fe_write_q <= fe_write;
                fe_addr_q  <= fe_addr;
                fe_wdata_q <= fe_wdata;
                fe_mask_q  <= fe_mask;
            end else if (grant_fe) begin
                fe_full_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            be_full_q  <= 1'b0;
            be_write_q <= 1'b0;
            be_addr_q  <= '0;
            be_wdata_q <= '0;
            be_mask_q  <= '0;
        end else begin
            if (acc_be) begin
                be_full_q  <= 1'b1;
                be_write_q <= be_write;
                be_addr_q  <= be_addr;
                be_wdata_q <= be_wdata;
                be_mask_q  <= be_mask;
            end else if (grant_be) begin
                be_full_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            out_write_q <= 1'b0;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            out_mask_q  <= '0;
            starve_q    <= '0;
        end else begin
            starve_q <= starve_d;
            if (can_load) begin
                out_valid_q <= grant_fe | grant_be;
                if (grant_be) begin
                    out_src_q   <= 1'b1;
                    out_write_q <= be_write_q;
                    out_addr_q  <= be_addr_q;
                    out_wdata_q <= be_wdata_q;
                    out_mask_q  <= be_mask_q;
                end else if (grant_fe) begin
                    out_src_q   <= 1'b0;
                    out_write_q <= fe_write_q;
                    out_addr_q  <= fe_addr_q;
                    out_wdata_q <= fe_wdata_q;
                    out_mask_q  <= fe_mask_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_write = out_write_q;
    assign out_addr  = out_addr_q;
    assign out_wdata = out_wdata_q;
    assign out_mask  = out_mask_q;

endmodule

// File: tb/tb_scpad_head_arb.sv
// Directed bench for scpad_head_arb. Accepted requests are pushed into
// per-source scoreboards; every output transfer pops and compares the payload.
module tb_scpad_head_arb;

    localparam int AW = 20;
    localparam int NC = 32;
    localparam int EW = 16;
    localparam int DW = NC * EW;
    localparam int SM = 8;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NC-1:0] m;
    } req_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic fe_valid = 1'b0, fe_write = 1'b0, be_valid = 1'b0, be_write = 1'b0;
    logic [AW-1:0] fe_addr = '0, be_addr = '0;
    logic [DW-1:0] fe_wdata, be_wdata;
    logic [NC-1:0] fe_mask, be_mask;
    logic fe_stall, be_stall;
    logic w_stall = 1'b0, r_stall = 1'b0;
    logic out_valid, out_src, out_write;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_wdata;
    logic [NC-1:0] out_mask;

    int checks = 0;
    int errors = 0;
    req_t fe_sb[$];
    req_t be_sb[$];

    function automatic logic [DW-1:0] mkd(input logic [AW-1:0] a);
        logic [15:0] e;
        e = a[15:0] ^ 16'hA5C3;
        return {NC{e}};
    endfunction

    function automatic logic [NC-1:0] mkm(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign fe_wdata = mkd(fe_addr);
    assign fe_mask  = mkm(fe_addr);
    assign be_wdata = mkd(be_addr);
    assign be_mask  = mkm(be_addr);

    always #5 clk = ~clk;

    scpad_head_arb #(.ADDR_W(AW), .NUM_COLS(NC), .ELEM_W(EW), .STARVE_MAX(SM)) dut (
        .clk(clk), .n_rst(n_rst),
        .fe_valid(fe_valid), .fe_write(fe_write), .fe_addr(fe_addr),
        .fe_wdata(fe_wdata), .fe_mask(fe_mask), .fe_stall(fe_stall),
        .be_valid(be_valid), .be_write(be_write), .be_addr(be_addr),
        .be_wdata(be_wdata), .be_mask(be_mask), .be_stall(be_stall),
        .w_stall(w_stall), .r_stall(r_stall),
        .out_valid(out_valid), .out_src(out_src), .out_write(out_write),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_mask(out_mask)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs change 1 after posedge, so negedge sees the
    // values that the next posedge will act on.
    always @(negedge clk) begin
        req_t got, exp;
        if (!n_rst) begin
            fe_sb.delete();
            be_sb.delete();
        end else begin
            if (out_valid && !(out_write ? w_stall : r_stall)) begin
                got = '{w: out_write, a: out_addr, d: out_wdata, m: out_mask};
                checks++;
                if ((out_src ? be_sb.size() : fe_sb.size()) == 0) begin
                    errors++;
                    $error("FAIL sb_empty src=%0d observed_addr=%0h expected=none", out_src, out_addr);
                end else begin
                    exp = out_src ? be_sb.pop_front() : fe_sb.pop_front();
                    assert (got === exp) else begin
                        errors++;
                        $error("FAIL sb_payload src=%0d observed_addr=%0h w=%0d expected_addr=%0h w=%0d",
                               out_src, got.a, got.w, exp.a, exp.w);
                    end
                end
            end
            if (fe_valid && !fe_stall)
                fe_sb.push_back('{w: fe_write, a: fe_addr, d: fe_wdata, m: fe_mask});
            if (be_valid && !be_stall)
                be_sb.push_back('{w: be_write, a: be_addr, d: be_wdata, m: be_mask});
        end
    end

    initial begin
        logic a_fe, a_be;
        logic [AW-1:0] snap_a;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stalls", 64'({fe_stall, be_stall}), 64'd0);
        chk("rst_out_pay", 64'({out_src, out_write, out_addr, out_mask}), 64'd0);
        chk("rst_out_wdata", 64'(|out_wdata), 64'd0);
        tick();
        n_rst = 1'b1;
        tick();

        // Single FE read, two-edge latency
        fe_valid = 1'b1; fe_write = 1'b0; fe_addr = 20'h00010;
        chk("rd1_fe_stall", 64'(fe_stall), 64'd0);
        tick();
        fe_valid = 1'b0;
        chk("rd1_not_yet", 64'(out_valid), 64'd0);
        chk("rd1_fe_stall_hold", 64'(fe_stall), 64'd0);
        tick();
        chk("rd1_valid", 64'(out_valid), 64'd1);
        chk("rd1_pay", 64'({out_src, out_write, out_addr}), 64'({1'b0, 1'b0, 20'h00010}));
        tick();
        chk("rd1_gone", 64'(out_valid), 64'd0);

        // Starvation guard: 8 BE, 1 FE, repeating
        fe_valid = 1'b1; fe_write = 1'b0; fe_addr = 20'h01000;
        be_valid = 1'b1; be_write = 1'b1; be_addr = 20'h02000;
        a_fe = fe_valid && !fe_stall; a_be = be_valid && !be_stall;
        tick();
        if (a_fe) fe_addr++;
        if (a_be) be_addr++;
        for (int j = 0; j < 18; j++) begin
            chk($sformatf("starve_fe_stall_%0d", j), 64'(fe_stall), 64'((j % 9) != 8));
            a_fe = fe_valid && !fe_stall; a_be = be_valid && !be_stall;
            tick();
            if (a_fe) fe_addr++;
            if (a_be) be_addr++;
            chk($sformatf("starve_src_%0d", j), 64'(out_src), 64'((j % 9) != 8));
        end
        fe_valid = 1'b0; be_valid = 1'b0;
        for (int k = 0; k < 30 && out_valid; k++) tick();
        chk("starve_drained", 64'(out_valid), 64'd0);

        // Blocked write holds output; release drains BE then FE
        be_valid = 1'b1; be_write = 1'b1; be_addr = 20'h00100;
        tick();
        be_valid = 1'b0;
        tick();
        w_stall = 1'b1;
        snap_a = out_addr;
        chk("wst_loaded", 64'({out_valid, out_write, out_addr}), 64'({1'b1, 1'b1, 20'h00100}));
        fe_valid = 1'b1; fe_write = 1'b0; fe_addr = 20'h00200;
        be_valid = 1'b1; be_write = 1'b1; be_addr = 20'h00101;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wst_hold_%0d", k), 64'({out_valid, out_src, out_addr}), 64'({1'b1, 1'b1, snap_a}));
            chk($sformatf("wst_stalls_%0d", k), 64'({fe_stall, be_stall}), 64'd3);
            tick();
        end
        w_stall = 1'b0; fe_valid = 1'b0; be_valid = 1'b0;
        tick();
        chk("wst_rel1", 64'({out_valid, out_src, out_addr}), 64'({1'b1, 1'b1, 20'h00101}));
        tick();
        chk("wst_rel2", 64'({out_valid, out_src, out_addr}), 64'({1'b1, 1'b0, 20'h00200}));
        tick();
        chk("wst_empty", 64'(out_valid), 64'd0);

        // BE back-to-back writes
        for (int i = 0; i < 4; i++) begin
            be_valid = 1'b1; be_write = 1'b1; be_addr = AW'(i);
            chk($sformatf("b2b_be_stall_%0d", i), 64'(be_stall), 64'd0);
            tick();
            if (i > 0)
                chk($sformatf("b2b_out_%0d", i - 1), 64'({out_valid, out_src, out_addr}), 64'({1'b1, 1'b1, AW'(i - 1)}));
        end
        be_valid = 1'b0;
        tick();
        chk("b2b_out_3", 64'({out_valid, out_src, out_addr}), 64'({1'b1, 1'b1, 20'd3}));
        tick();

        // Reset mid-operation
        fe_valid = 1'b1; fe_write = 1'b1; fe_addr = 20'h00400;
        be_valid = 1'b1; be_write = 1'b1; be_addr = 20'h00500;
        tick();
        tick();
        w_stall = 1'b1;
        tick();
        chk("mrst_pre", 64'({out_valid, fe_stall, be_stall}), 64'd7);
        n_rst = 1'b0;
        fe_valid = 1'b0; be_valid = 1'b0; w_stall = 1'b0;
        #1;
        chk("mrst_out", 64'({out_valid, out_src, out_write, out_addr, out_mask}), 64'd0);
        chk("mrst_wdata", 64'(|out_wdata), 64'd0);
        chk("mrst_stalls", 64'({fe_stall, be_stall}), 64'd0);
        tick();
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mrst_quiet_%0d", k), 64'(out_valid), 64'd0);
        end

        // Blocked read keeps a pending write behind it
        fe_valid = 1'b1; fe_write = 1'b0; fe_addr = 20'h00300;
        tick();
        fe_valid = 1'b0;
        tick();
        r_stall = 1'b1;
        be_valid = 1'b1; be_write = 1'b1; be_addr = 20'h00301;
        tick();
        be_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_read_hold_%0d", k), 64'({out_valid, out_write, out_addr}), 64'({1'b1, 1'b0, 20'h00300}));
            chk($sformatf("rst_be_stall_%0d", k), 64'(be_stall), 64'd1);
            tick();
        end
        r_stall = 1'b0;
        tick();
        chk("rst_write_next", 64'({out_valid, out_src, out_write, out_addr}), 64'({1'b1, 1'b1, 1'b1, 20'h00301}));
        tick();
        chk("rst_final_empty", 64'(out_valid), 64'd0);
        tick();
        chk("sb_left", 64'(fe_sb.size() + be_sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scpad_head_arb.md
# scpad_head_arb

Per-scratchpad request head: accepts frontend (FE) and backend (BE) SRAM requests, buffers one request per source, arbitrates BE-over-FE with a starvation guard, and drives a registered request into the body write crossbar. Sits between the FE/BE request ports and the head-to-stomach request path, one instance per scratchpad. It honours separate write/read backpressure from the SRAM controller.

## Interface
Parameters:
- ADDR_W, 20, request row/element address width
- NUM_COLS, 32, columns per request; mask width
- ELEM_W, 16, bits per column element; data width = NUM_COLS*ELEM_W
- STARVE_MAX, 8, consecutive BE grants tolerated while FE waits (≥1)

Ports:
- Clock and reset: one clock `clk`; reset `n_rst`, asynchronous, active-low.
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- fe_valid  input  1  FE request present
- fe_write  input  1  1 = write, 0 = read
- fe_addr  input  ADDR_W  FE address
- fe_wdata  input  NUM_COLS*ELEM_W  FE write data
- fe_mask  input  NUM_COLS  FE column enable
- fe_stall  output  1  FE must hold its request
- be_valid, be_write, be_addr, be_wdata, be_mask  input  (as FE)  BE request
- be_stall  output  1  BE must hold its request
- w_stall  input  1  downstream cannot take a write
- r_stall  input  1  downstream cannot take a read
- out_valid  output  1  request toward body valid
- out_src  output  1  0 = FE, 1 = BE
- out_write, out_addr, out_wdata, out_mask  output  (as FE)  request payload

## Operation
- Per source x∈{fe,be}: one-entry hold register (hold_x_full plus payload).
- Output stage: one register (out_*). blocked = out_valid & (out_write ? w_stall : r_stall). can_load = !out_valid | !blocked.
- Grant (combinational): if can_load, among full hold registers pick BE unless starve_cnt == STARVE_MAX and FE full, then FE. Only one grant per cycle.
- x_stall = hold_x_full & !grant_x. Accept_x = x_valid & !x_stall; on accept, hold_x loads payload (simultaneous grant-out and accept of the same source is legal: old entry moves to output, new entry loads).
- On can_load: out_* loads granted entry with out_src; if no grant, out_valid←0. When blocked, all out_* held stable.
- starve_cnt (width clog2(STARVE_MAX+1)): +1 (saturating at STARVE_MAX) when BE granted while FE hold full; cleared when FE granted or FE hold empty.
- Per-source order preserved; no cross-source address hazard checks (caller's responsibility).
- Read and write stalls gate only the output entry's type; a blocked read does not let a write bypass it.

## Timing
- Reset (async, immediate): hold_fe_full=hold_be_full=0, out_valid=0, out_src=0, out_write=0, out_addr/wdata/mask=0, starve_cnt=0; fe_stall=be_stall=0.
- Latency: request accepted at edge N → in hold during cycle N+1 → out_valid at N+2 if granted (2 cycles, no bypass).
- Throughput: one request per cycle total when unblocked; a lone source sustains 1/cycle.
- Stalls are combinational from w_stall/r_stall through blocked/grant; no comb path from x_valid to any output.
- Reset mid-operation discards all buffered requests; no output pulse after n_rst deasserts until a new accept.
- Both holds full and out blocked: both stalls high; no state changes except upstream hold.

## Test plan
- Single FE read addr=0x00010, w_stall=r_stall=0 → out_valid at cycle+2, out_src=0, out_write=0, addr 0x00010; fe_stall never asserted.
- FE and BE valid every cycle, STARVE_MAX=8, no stalls → out_src pattern: 8 BE, 1 FE, repeating; fe_stall high on cycles FE not granted.
- Output holding a write, w_stall=1 for 5 cycles, r_stall=0 → out_* unchanged 5 cycles, both stalls high once holds fill; release → drains in BE-first order.
- BE back-to-back writes addr 0,1,2,3 with no stalls → out addrs 0,1,2,3 on consecutive cycles, be_stall stays 0.
- Assert n_rst low with both holds full and out_valid=1 → all outputs zero immediately; after release, out_valid stays 0 until a new request is accepted.
- out holds a read with r_stall=1, w_stall=0, BE write pending → write not issued until read leaves; out order read then write.
